y_signature_collector: RTL and testbench

- Downstream consumer of the fuzz top's wide output bus `y`.
- Samples `y` once per clock while `sample_valid` is high and compresses it into a 32-bit MISR signature.
- Stops after a programmed number of samples and reports the signature plus a match flag against an expected value.
- Lets simulation and post-synthesis netlists be compared by signature instead of by a full `$strobe` dump.

---
 rtl/y_signature_collector.sv | 145 ++++++++++++++
 tb/tb_y_signature_collector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_signature_collector.sv
// y_signature_collector: compresses a wide sampled bus into a MISR signature.
// A run loads SEED, accepts a programmed number of valid samples, then holds
// the final signature together with a registered compare against a golden value.
module y_signature_collector #(
  parameter int                DATA_W = 474,
  parameter int                SIG_W  = 32,
  parameter logic [SIG_W-1:0]  POLY   = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SEED   = 32'hFFFFFFFF,
  parameter int                CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count,
  output logic              match
);

  // Number of SIG_W-wide slices after zero-extending the sampled bus.
  localparam int NSL   = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int EXT_W = NSL * SIG_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic              match_q, match_d;

  logic              load;
  logic              accept;
  logic              last_accept;
  logic [EXT_W-1:0]  data_ext;
  logic [SIG_W-1:0]  fold_chain [0:NSL];
  logic [SIG_W-1:0]  sig_step;

  // Fold: XOR of all zero-extended SIG_W slices of the sample.
  assign data_ext      = EXT_W'(sample_data);
  assign fold_chain[0] = '0;

  generate
    for (genvar gi = 0; gi < NSL; gi++) begin : g_fold
      assign fold_chain[gi+1] = fold_chain[gi] ^ data_ext[gi*SIG_W +: SIG_W];
    end
  endgenerate

  // Galois-style shift of the current signature with polynomial feedback.
  assign sig_step = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0);

  // A start is honoured anywhere except mid-run; a run with target 0 never
  // accepts, so the count comparison also guards the zero-length case.
  assign load        = start && (state_q != S_COLLECT);
  assign accept      = (state_q == S_COLLECT) && sample_valid && (cnt_q != target_q);
  assign last_accept = accept && ((cnt_q + CNT_W'(1)) == target_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        // Zero-target runs pass through COLLECT for one cycle, then finish.
        if (cnt_q == target_q || last_accept) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_COLLECT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_COLLECT: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next-state: load on start, compress on each accepted sample.
  always_comb begin
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (load) begin
      sig_d    = SEED;
      cnt_d    = '0;
      target_d = num_samples;
    end else if (accept) begin
      sig_d = sig_step ^ fold_chain[NSL];
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Compare against the value the signature is about to take, so match
    // is already valid in the cycle done first rises.
    match_d = (sig_d == expected_sig);
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q    <= SEED;
      cnt_q    <= '0;
      target_q <= '0;
      match_q  <= 1'b0;
    end else begin
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      match_q  <= match_d;
    end
  end

  assign signature    = sig_q;
  assign sample_count = cnt_q;
  assign match        = match_q;

endmodule

// File: tb/tb_y_signature_collector.sv
// Bench for y_signature_collector: directed scenarios plus randomized runs
// checked against a bit-level reference model of the signature.
module tb_y_signature_collector;

  localparam int DATA_W = 474;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic              clk;
  logic              rst;
  logic              start;
  logic [15:0]       num_samples;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [31:0]       expected_sig;

  logic        busy_a, done_a, match_a;
  logic [31:0] sig_a;
  logic [15:0] cnt_a;
  logic        busy_b, done_b, match_b;
  logic [31:0] sig_b;
  logic [15:0] cnt_b;

  int checks = 0;
  int errors = 0;

  // Default SEED instance.
  y_signature_collector dut_a (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .expected_sig(expected_sig), .busy(busy_a), .done(done_a),
    .signature(sig_a), .sample_count(cnt_a), .match(match_a)
  );

  // Zero SEED instance, fed with identical stimulus.
  y_signature_collector #(.SEED(32'h0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .expected_sig(expected_sig), .busy(busy_b), .done(done_b),
    .signature(sig_b), .sample_count(cnt_b), .match(match_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] step_m(input logic [31:0] s);
    logic [31:0] r;
    r = s << 1;
    if (s >= 32'h80000000) r = r ^ POLY;
    return r;
  endfunction

  function automatic logic [31:0] fold_m(input logic [DATA_W-1:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i % 32] = r[i % 32] ^ d[i];
    return r;
  endfunction

  function automatic logic [31:0] model_sig(input logic [31:0] seed,
                                            input logic [DATA_W-1:0] q[$]);
    logic [31:0] s;
    s = seed;
    foreach (q[k]) s = step_m(s) ^ fold_m(q[k]);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [479:0] t;
    for (int i = 0; i < 15; i++) t[i*32 +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_samples = 16'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
    checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL reset_match got %b exp 0", match_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_a); end
    checks++; if (sig_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_sig got %h exp ffffffff", sig_a); end
    checks++; if (sig_b !== 32'h0) begin errors++; $display("FAIL reset_sig_seed0 got %h exp 00000000", sig_b); end
    tick();
    rst = 1'b0;
    tick();
    // Abort mid-run: reset takes effect without a clock edge.
    do_start(10);
    for (int i = 0; i < 3; i++) send(rand_data());
    checks++; if (cnt_a !== 16'd3) begin errors++; $display("FAIL midrun_count got %0d exp 3", cnt_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL async_busy got %b exp 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL async_done got %b exp 0", done_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL async_count got %0d exp 0", cnt_a); end
    checks++; if (sig_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL async_sig got %h exp ffffffff", sig_a); end
    tick();
    rst = 1'b0;
    tick();
    $display("reset: mid-run abort sig=%h cnt=%0d", sig_a, cnt_a);
  endtask

  task automatic test_single();
    do_start(1);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b exp 1", busy_a); end
    send('0);
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy_a); end
    checks++; if (sig_a !== 32'hFB3EE249) begin errors++; $display("FAIL single_sig got %h exp fb3ee249", sig_a); end
    checks++; if (cnt_a !== 16'd1) begin errors++; $display("FAIL single_count got %0d exp 1", cnt_a); end
    $display("single: sig=%h cnt=%0d", sig_a, cnt_a);
  endtask

  task automatic test_gap();
    logic [DATA_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    do_start(2);
    send(one);
    for (int i = 0; i < 3; i++) begin
      sample_data = rand_data();
      tick();
      checks++; if (cnt_b !== 16'd1) begin errors++; $display("FAIL gap_count got %0d exp 1", cnt_b); end
    end
    checks++; if (sig_b !== 32'h1) begin errors++; $display("FAIL gap_hold_sig got %h exp 00000001", sig_b); end
    send(one);
    checks++; if (sig_b !== 32'h3) begin errors++; $display("FAIL gap_sig got %h exp 00000003", sig_b); end
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL gap_done got %b exp 1", done_b); end
    $display("gap: sig=%h cnt=%0d", sig_b, cnt_b);
  endtask

  task automatic test_fold();
    logic [DATA_W-1:0] d;
    d = '0;
    d[0] = 1'b1;
    d[32] = 1'b1;
    do_start(1);
    send(d);
    checks++; if (sig_b !== 32'h0) begin errors++; $display("FAIL fold_cancel got %h exp 00000000", sig_b); end
    d = '0;
    d[473] = 1'b1;
    do_start(1);
    send(d);
    checks++; if (sig_b !== 32'h02000000) begin errors++; $display("FAIL fold_top got %h exp 02000000", sig_b); end
    $display("fold: top-bit sig=%h", sig_b);
  endtask

  task automatic test_zero();
    expected_sig = 32'hFFFFFFFF;
    do_start(0);
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL zero_done_early got %b exp 0", done_a); end
    tick();
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done_a); end
    checks++; if (sig_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL zero_sig got %h exp ffffffff", sig_a); end
    checks++; if (match_a !== 1'b1) begin errors++; $display("FAIL zero_match got %b exp 1", match_a); end
    expected_sig = 32'hFFFFFFFE;
    tick();
    checks++; if (match_a !== 1'b0) begin errors++; $display("FAIL zero_nomatch got %b exp 0", match_a); end
    $display("zero: sig=%h match=%b", sig_a, match_a);
  endtask

  task automatic test_restart();
    logic [DATA_W-1:0] q[$];
    logic [31:0] exp_sig;
    for (int i = 0; i < 5; i++) q.push_back(rand_data());
    exp_sig = model_sig(32'hFFFFFFFF, q);
    do_start(5);
    send(q[0]);
    send(q[1]);
    start = 1'b1;
    num_samples = 16'd1;
    tick();
    start = 1'b0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL restart_ignored_busy got %b exp 1", busy_a); end
    checks++; if (cnt_a !== 16'd2) begin errors++; $display("FAIL restart_ignored_count got %0d exp 2", cnt_a); end
    for (int i = 2; i < 5; i++) send(q[i]);
    checks++; if (sig_a !== exp_sig) begin errors++; $display("FAIL restart_sig got %h exp %h", sig_a, exp_sig); end
    checks++; if (cnt_a !== 16'd5) begin errors++; $display("FAIL restart_count got %0d exp 5", cnt_a); end
    do_start(2);
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rerun_done got %b exp 0", done_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rerun_busy got %b exp 1", busy_a); end
    checks++; if (sig_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL rerun_seed got %h exp ffffffff", sig_a); end
    checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL rerun_count got %0d exp 0", cnt_a); end
    q.delete();
    q.push_back(rand_data());
    q.push_back(rand_data());
    send(q[0]);
    send(q[1]);
    exp_sig = model_sig(32'hFFFFFFFF, q);
    checks++; if (sig_a !== exp_sig) begin errors++; $display("FAIL rerun_sig got %h exp %h", sig_a, exp_sig); end
    $display("restart: sig=%h cnt=%0d", sig_a, cnt_a);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] q[$];
    logic [31:0] exp_a, exp_b, held;
    logic want;
    int n;
    for (int run = 0; run < 20; run++) begin
      q.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) q.push_back(rand_data());
      exp_a = model_sig(32'hFFFFFFFF, q);
      exp_b = model_sig(32'h0, q);
      want = 1'($urandom_range(0, 1));
      expected_sig = want ? exp_a : (exp_a ^ 32'h80000001);
      do_start(n);
      for (int i = 0; i < n; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          sample_data = rand_data();
          tick();
        end
        send(q[i]);
      end
      checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL rand_done run %0d got %b exp 1", run, done_a); end
      checks++; if (sig_a !== exp_a) begin errors++; $display("FAIL rand_sig run %0d got %h exp %h", run, sig_a, exp_a); end
      checks++; if (sig_b !== exp_b) begin errors++; $display("FAIL rand_sig_seed0 run %0d got %h exp %h", run, sig_b, exp_b); end
      checks++; if (cnt_a !== 16'(n)) begin errors++; $display("FAIL rand_count run %0d got %0d exp %0d", run, cnt_a, n); end
      checks++; if (match_a !== want) begin errors++; $display("FAIL rand_match run %0d got %b exp %b", run, match_a, want); end
      // Samples offered while DONE must be ignored.
      held = exp_a;
      send(rand_data());
      checks++; if (sig_a !== held) begin errors++; $display("FAIL rand_done_hold run %0d got %h exp %h", run, sig_a, held); end
      $display("run %0d: n=%0d sig=%h match=%b", run, n, sig_a, match_a);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_samples = '0;
    sample_valid = 1'b0;
    sample_data = '0;
    expected_sig = '0;
    #1;
    test_reset();
    test_single();
    test_gap();
    test_fold();
    test_zero();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
